// File: rtl/slice_packer.sv
// slice_packer: packs IN_W-bit slices LSB-first into SLICES-wide words,
// supports early flush via in_last, and buffers completed words in a
// DEPTH-entry FIFO with a valid/ready output handshake.
module slice_packer #(
  parameter int IN_W   = 4,
  parameter int SLICES = 2,
  parameter int DEPTH  = 2,
  localparam int CW    = $clog2(SLICES + 1),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [IN_W*SLICES-1:0] out_data,
  output logic [CW-1:0]          out_cnt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LW-1:0]          level
);

  localparam int W  = IN_W * SLICES;
  localparam int IW = $clog2(SLICES);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_acc;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_mem_data [DEPTH];
  logic [CW-1:0] r_mem_cnt  [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic          w_accept;
  logic          w_done;
  logic          w_pop;
  logic [W-1:0]  w_word;
  logic [CW-1:0] w_cnt;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // in_ready depends only on registered occupancy, never on out_ready
  assign in_ready  = (r_level < LW'(DEPTH));
  assign out_valid = (r_level != '0);
  assign level     = r_level;
  assign out_data  = out_valid ? r_mem_data[r_rptr] : '0;
  assign out_cnt   = out_valid ? r_mem_cnt[r_rptr]  : '0;

  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;
  assign w_done   = w_accept && (in_last || (r_idx == IW'(SLICES - 1)));
  // accumulator positions above r_idx are always zero, so OR-merge is exact
  assign w_word   = r_acc | ({{(W - IN_W){1'b0}}, in_data} << (32'(r_idx) * IN_W));
  assign w_cnt    = CW'(r_idx) + CW'(1);

  // Accumulator, slice index, FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_idx   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_done) begin
        r_acc  <= '0;
        r_idx  <= '0;
        r_wptr <= f_next(r_wptr);
      end else if (w_accept) begin
        r_acc <= w_word;
        r_idx <= r_idx + IW'(1);
      end
      if (w_pop) begin
        r_rptr <= f_next(r_rptr);
      end
      case ({w_done, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage; contents are only visible while occupancy covers them
  always_ff @(posedge clk) begin
    if (w_done) begin
      r_mem_data[r_wptr] <= w_word;
      r_mem_cnt[r_wptr]  <= w_cnt;
    end
  end

endmodule

// File: tb/tb_slice_packer.sv
// tb_slice_packer: directed and randomized checks of slice_packer against a
// queue-based reference model, for default and (8,4,3) parameter sets.
module tb_slice_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: defaults IN_W=4, SLICES=2, DEPTH=2
  logic       a_rst_n, a_in_valid, a_in_last, a_in_ready, a_out_valid, a_out_ready;
  logic [3:0] a_in_data;
  logic [7:0] a_out_data;
  logic [1:0] a_out_cnt;
  logic [1:0] a_level;

  // Instance B: IN_W=8, SLICES=4, DEPTH=3
  logic        b_rst_n, b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data;
  logic [31:0] b_out_data;
  logic [2:0]  b_out_cnt;
  logic [1:0]  b_level;

  slice_packer #(.IN_W(4), .SLICES(2), .DEPTH(2)) u_a (
    .clk(clk), .rst_n(a_rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_last(a_in_last), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_cnt(a_out_cnt), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .level(a_level)
  );

  slice_packer #(.IN_W(8), .SLICES(4), .DEPTH(3)) u_b (
    .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_last(b_in_last), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_cnt(b_out_cnt), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .level(b_level)
  );

  // Reference model state: pending slices of the open word, queued words
  logic [31:0] a_cur[$];
  logic [31:0] aq_w[$];
  int          aq_c[$];
  logic [31:0] a_obs[$];
  logic        a_acc;

  logic [31:0] b_cur[$];
  logic [31:0] bq_w[$];
  int          bq_c[$];
  int          b_pops = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One cycle on A: check outputs against model, drive inputs, advance model and clock
  task automatic stepA(input logic v, input logic [3:0] d, input logic last, input logic ordy);
    logic        pop;
    logic [31:0] word;
    a_in_valid = v; a_in_data = d; a_in_last = last; a_out_ready = ordy;
    chk("A.level", 32'(a_level), aq_w.size());
    chk("A.in_ready", 32'(a_in_ready), 32'(aq_w.size() < 2));
    chk("A.out_valid", 32'(a_out_valid), 32'(aq_w.size() != 0));
    chk("A.out_data", 32'(a_out_data), (aq_w.size() != 0) ? aq_w[0] : 32'd0);
    chk("A.out_cnt", 32'(a_out_cnt), (aq_c.size() != 0) ? aq_c[0] : 0);
    pop   = (aq_w.size() != 0) && ordy;
    a_acc = v && (aq_w.size() < 2);
    if (pop) begin
      a_obs.push_back(32'(a_out_data));
      void'(aq_w.pop_front());
      void'(aq_c.pop_front());
    end
    if (a_acc) begin
      a_cur.push_back(32'(d));
      if (last || a_cur.size() == 2) begin
        word = 0;
        foreach (a_cur[i]) word = word | (a_cur[i] << (4 * i));
        aq_w.push_back(word);
        aq_c.push_back(a_cur.size());
        a_cur.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic stepB(input logic v, input logic [7:0] d, input logic last, input logic ordy);
    logic        pop;
    logic        acc;
    logic [31:0] word;
    b_in_valid = v; b_in_data = d; b_in_last = last; b_out_ready = ordy;
    chk("B.level", 32'(b_level), bq_w.size());
    chk("B.in_ready", 32'(b_in_ready), 32'(bq_w.size() < 3));
    chk("B.out_valid", 32'(b_out_valid), 32'(bq_w.size() != 0));
    chk("B.out_data", b_out_data, (bq_w.size() != 0) ? bq_w[0] : 32'd0);
    chk("B.out_cnt", 32'(b_out_cnt), (bq_c.size() != 0) ? bq_c[0] : 0);
    pop = (bq_w.size() != 0) && ordy;
    acc = v && (bq_w.size() < 3);
    if (pop) begin
      b_pops++;
      void'(bq_w.pop_front());
      void'(bq_c.pop_front());
    end
    if (acc) begin
      b_cur.push_back(32'(d));
      if (last || b_cur.size() == 4) begin
        word = 0;
        foreach (b_cur[i]) word = word | (b_cur[i] << (8 * i));
        bq_w.push_back(word);
        bq_c.push_back(b_cur.size());
        b_cur.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic resetA();
    a_in_valid = 1'b0; a_in_last = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    a_rst_n = 1'b0;
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    a_cur.delete(); aq_w.delete(); aq_c.delete();
  endtask

  initial begin
    int d;
    int target;
    a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_last = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_last = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // Reset state
    chk("rst.A.out_valid", 32'(a_out_valid), 0);
    chk("rst.A.level", 32'(a_level), 0);
    chk("rst.A.in_ready", 32'(a_in_ready), 1);
    chk("rst.A.out_data", 32'(a_out_data), 0);
    chk("rst.A.out_cnt", 32'(a_out_cnt), 0);
    chk("rst.B.out_valid", 32'(b_out_valid), 0);
    chk("rst.B.in_ready", 32'(b_in_ready), 1);

    // Basic pack
    stepA(1, 4'h3, 0, 1);
    stepA(1, 4'hA, 0, 1);
    chk("basic.data", 32'(a_out_data), 32'hA3);
    chk("basic.cnt", 32'(a_out_cnt), 2);
    chk("basic.valid", 32'(a_out_valid), 1);
    stepA(0, 4'h0, 0, 1);
    chk("basic.valid_one_cycle", 32'(a_out_valid), 0);

    // Flush, then idx restarts at zero
    stepA(1, 4'h5, 1, 1);
    chk("flush.data", 32'(a_out_data), 32'h05);
    chk("flush.cnt", 32'(a_out_cnt), 1);
    stepA(1, 4'h1, 0, 1);
    stepA(1, 4'h2, 0, 1);
    chk("flush.next_data", 32'(a_out_data), 32'h21);
    chk("flush.next_cnt", 32'(a_out_cnt), 2);
    stepA(0, 4'h0, 0, 1);

    // Backpressure: stream 1..6 with out_ready low
    a_obs.delete();
    for (int i = 1; i <= 6; i++) stepA(1, 4'(i), 0, 0);
    chk("bp.level", 32'(a_level), 2);
    chk("bp.in_ready", 32'(a_in_ready), 0);
    chk("bp.head", 32'(a_out_data), 32'h21);
    d = 5;
    for (int n = 0; n < 20 && d <= 6; n++) begin
      stepA(1, 4'(d), 0, 1);
      if (a_acc) d++;
    end
    chk("bp.resend_done", 32'(d), 7);
    repeat (3) stepA(0, 4'h0, 0, 1);
    chk("bp.pop_count", a_obs.size(), 3);
    chk("bp.pop0", a_obs[0], 32'h21);
    chk("bp.pop1", a_obs[1], 32'h43);
    chk("bp.pop2", a_obs[2], 32'h65);

    // Full-edge pop with a slice presented: not accepted on that edge
    stepA(1, 4'h7, 0, 0);
    stepA(1, 4'h8, 0, 0);
    stepA(1, 4'h9, 0, 0);
    stepA(1, 4'h1, 0, 0);
    chk("full.in_ready", 32'(a_in_ready), 0);
    stepA(1, 4'h2, 0, 1);
    chk("full.in_ready_after_pop", 32'(a_in_ready), 1);
    chk("full.level_after_pop", 32'(a_level), 1);
    stepA(1, 4'h2, 0, 0);
    stepA(1, 4'h3, 0, 0);
    chk("full.level_refill", 32'(a_level), 2);
    repeat (3) stepA(0, 4'h0, 0, 1);

    // Reset mid-word discards the partial slice
    stepA(1, 4'h7, 0, 1);
    resetA();
    chk("midrst.level", 32'(a_level), 0);
    chk("midrst.out_valid", 32'(a_out_valid), 0);
    chk("midrst.in_ready", 32'(a_in_ready), 1);
    stepA(1, 4'h1, 0, 1);
    stepA(1, 4'h2, 0, 1);
    chk("midrst.data", 32'(a_out_data), 32'h21);
    chk("midrst.cnt", 32'(a_out_cnt), 2);
    stepA(0, 4'h0, 0, 1);

    // Parameter set B: full word and flushed single slice
    stepB(1, 8'h11, 0, 1);
    stepB(1, 8'h22, 0, 1);
    stepB(1, 8'h33, 0, 1);
    stepB(1, 8'h44, 0, 1);
    chk("B.full.data", b_out_data, 32'h44332211);
    chk("B.full.cnt", 32'(b_out_cnt), 4);
    stepB(1, 8'hAA, 1, 1);
    chk("B.flush.data", b_out_data, 32'h000000AA);
    chk("B.flush.cnt", 32'(b_out_cnt), 1);
    stepB(0, 8'h00, 0, 1);

    // Randomized traffic on B until 20 more words have left
    target = b_pops + 20;
    for (int n = 0; n < 3000 && b_pops < target; n++) begin
      stepB($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1);
    end
    chk("B.random.words_done", 32'(b_pops >= target), 1);
    for (int n = 0; n < 20 && bq_w.size() != 0; n++) stepB(0, 8'h00, 0, 1);
    chk("B.random.drained", 32'(b_out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
